// File: rtl/saber_swing_tracker.sv
// Saber swing tracker: builds the per-frame swing segment (start/current tip) and registers one hit per swing.
// Optional swing length limit enabled by defining SABER_SWING_TIMEOUT_EN.
module saber_swing_tracker #(
    parameter int SWING_THRESH     = 16,
    parameter int STILL_FRAMES     = 3,
    parameter int COOLDOWN_FRAMES  = 10,
    parameter int MAX_SWING_FRAMES = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] tip_x_in,
    input  logic [9:0]  tip_y_in,
    input  logic        tip_valid_in,
    input  logic        is_intersecting_in,
    output logic [10:0] saber_start_x,
    output logic [9:0]  saber_start_y,
    output logic [10:0] saber_current_x,
    output logic [9:0]  saber_current_y,
    output logic        swing_active,
    output logic        swing_done,
    output logic        hit_out,
    output logic        hit_latched
);
    typedef enum logic [1:0] {IDLE, SWING, COOLDOWN} state_t;

    state_t      state;
    logic [10:0] prev_x;
    logic [9:0]  prev_y;
    logic        prev_valid;
    logic [3:0]  still_cnt;
    logic [7:0]  cooldown_cnt;

    logic [11:0] dx, dy, disp;
    logic        motion, still_end, swing_end, start_swing;

    always_comb begin
        dx = (tip_x_in >= prev_x) ? {1'b0, tip_x_in - prev_x} : {1'b0, prev_x - tip_x_in};
        dy = (tip_y_in >= prev_y) ? {2'b00, tip_y_in - prev_y} : {2'b00, prev_y - tip_y_in};
        disp        = dx + dy;
        motion      = disp >= 12'(SWING_THRESH);
        start_swing = (state == IDLE) && tip_valid_in && prev_valid && motion;
        still_end   = !motion && (({1'b0, still_cnt} + 5'd1) == 5'(STILL_FRAMES));
    end

`ifdef SABER_SWING_TIMEOUT_EN
    logic [7:0] swing_frames;
    logic       frames_end;

    assign frames_end = ({1'b0, swing_frames} + 9'd1) == 9'(MAX_SWING_FRAMES);
    assign swing_end  = still_end || frames_end;

    always_ff @(posedge clk_in) begin
        if (rst_in || start_swing)
            swing_frames <= 8'd0;
        else if (state == SWING && tip_valid_in)
            swing_frames <= swing_frames + 8'd1;
    end
`else
    assign swing_end = still_end;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            prev_x          <= '0;
            prev_y          <= '0;
            prev_valid      <= 1'b0;
            still_cnt       <= '0;
            cooldown_cnt    <= '0;
            saber_start_x   <= '0;
            saber_start_y   <= '0;
            saber_current_x <= '0;
            saber_current_y <= '0;
            swing_active    <= 1'b0;
            swing_done      <= 1'b0;
            hit_out         <= 1'b0;
            hit_latched     <= 1'b0;
        end else begin
            swing_done <= 1'b0;
            hit_out    <= 1'b0;
            if (tip_valid_in) begin
                prev_x     <= tip_x_in;
                prev_y     <= tip_y_in;
                prev_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_swing) begin
                        saber_start_x   <= prev_x;
                        saber_start_y   <= prev_y;
                        saber_current_x <= tip_x_in;
                        saber_current_y <= tip_y_in;
                        hit_latched     <= 1'b0;
                        still_cnt       <= '0;
                        swing_active    <= 1'b1;
                        state           <= SWING;
                    end
                end
                SWING: begin
                    // The detector looks at the segment currently on the outputs,
                    // so the hit is taken before this cycle's coordinate update lands.
                    if (is_intersecting_in && !hit_latched) begin
                        hit_out     <= 1'b1;
                        hit_latched <= 1'b1;
                    end
                    if (tip_valid_in) begin
                        saber_current_x <= tip_x_in;
                        saber_current_y <= tip_y_in;
                        if (swing_end) begin
                            swing_done   <= 1'b1;
                            swing_active <= 1'b0;
                            still_cnt    <= '0;
                            cooldown_cnt <= 8'(COOLDOWN_FRAMES);
                            state        <= (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
                        end else if (motion) begin
                            still_cnt <= '0;
                        end else begin
                            still_cnt <= still_cnt + 4'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (tip_valid_in) begin
                        cooldown_cnt <= cooldown_cnt - 8'd1;
                        if (cooldown_cnt <= 8'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_saber_swing_tracker.sv
// Scoreboarded bench for saber_swing_tracker: directed swing scenarios plus randomized tip traffic.
module tb_saber_swing_tracker;
    localparam int THRESH = 16;
    localparam int STILL  = 3;
    localparam int COOL   = 10;
    localparam int MAXF   = 4;

    typedef struct packed {
        logic [10:0] sx;
        logic [9:0]  sy;
        logic [10:0] cx;
        logic [9:0]  cy;
        logic        act;
        logic        done;
        logic        hit;
        logic        lat;
    } outs_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [10:0] tip_x_in = '0;
    logic [9:0]  tip_y_in = '0;
    logic        tip_valid_in = 1'b0;
    logic        is_intersecting_in = 1'b0;
    logic [10:0] saber_start_x, saber_current_x;
    logic [9:0]  saber_start_y, saber_current_y;
    logic        swing_active, swing_done, hit_out, hit_latched;

    saber_swing_tracker #(
        .SWING_THRESH(THRESH), .STILL_FRAMES(STILL),
        .COOLDOWN_FRAMES(COOL), .MAX_SWING_FRAMES(MAXF)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .tip_x_in(tip_x_in), .tip_y_in(tip_y_in),
        .tip_valid_in(tip_valid_in), .is_intersecting_in(is_intersecting_in),
        .saber_start_x(saber_start_x), .saber_start_y(saber_start_y),
        .saber_current_x(saber_current_x), .saber_current_y(saber_current_y),
        .swing_active(swing_active), .swing_done(swing_done),
        .hit_out(hit_out), .hit_latched(hit_latched)
    );

    always #5 clk_in = ~clk_in;

    outs_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 = idle, 1 = swinging, 2 = cooling down.
    int    m_mode, m_px, m_py, m_still, m_cool, m_frames;
    bit    m_have_prev;
    outs_t m_out;

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_step(input bit rst, input bit v, input int x, input int y, input bit isect);
        bit moving;
        bit timed_out;
        if (rst) begin
            m_mode = 0; m_have_prev = 0; m_px = 0; m_py = 0;
            m_still = 0; m_cool = 0; m_frames = 0;
            m_out = '0;
        end else begin
            m_out.done = 0;
            m_out.hit  = 0;
            if (m_mode == 1 && isect && !m_out.lat) begin
                m_out.hit = 1;
                m_out.lat = 1;
            end
            if (v) begin
                moving = m_have_prev && (absdiff(x, m_px) + absdiff(y, m_py) >= THRESH);
                if (m_mode == 0) begin
                    if (moving) begin
                        m_out.sx = 11'(m_px); m_out.sy = 10'(m_py);
                        m_out.cx = 11'(x);    m_out.cy = 10'(y);
                        m_out.lat = 0;
                        m_still = 0; m_frames = 0; m_mode = 1;
                    end
                end else if (m_mode == 1) begin
                    m_out.cx = 11'(x); m_out.cy = 10'(y);
                    m_frames++;
                    m_still = moving ? 0 : m_still + 1;
                    timed_out = 0;
`ifdef SABER_SWING_TIMEOUT_EN
                    timed_out = (m_frames == MAXF);
`endif
                    if (m_still == STILL || timed_out) begin
                        m_out.done = 1;
                        m_still = 0;
                        m_cool  = COOL;
                        m_mode  = (COOL > 0) ? 2 : 0;
                    end
                end else begin
                    m_cool--;
                    if (m_cool <= 0) m_mode = 0;
                end
                m_px = x; m_py = y; m_have_prev = 1;
            end
            m_out.act = (m_mode == 1);
        end
        exp_q.push_back(m_out);
    endtask

    task automatic cyc(input bit rst, input bit v, input int x, input int y, input bit isect);
        @(negedge clk_in);
        rst_in = rst;
        tip_valid_in = v;
        tip_x_in = 11'(x);
        tip_y_in = 10'(y);
        is_intersecting_in = isect;
        model_step(rst, v, x, y, isect);
    endtask

    task automatic sample(input int x, input int y);
        cyc(0, 1, x, y, 0);
        cyc(0, 0, x, y, 0);
    endtask

    // Monitor: every cycle the DUT presents a registered output vector.
    initial begin
        outs_t e, a;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {saber_start_x, saber_start_y, saber_current_x, saber_current_y,
                     swing_active, swing_done, hit_out, hit_latched};
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL outputs t=%0t got sx=%0d sy=%0d cx=%0d cy=%0d act=%b done=%b hit=%b lat=%b want sx=%0d sy=%0d cx=%0d cy=%0d act=%b done=%b hit=%b lat=%b",
                              $time, a.sx, a.sy, a.cx, a.cy, a.act, a.done, a.hit, a.lat,
                              e.sx, e.sy, e.cx, e.cy, e.act, e.done, e.hit, e.lat);
            end
        end
    end

    initial begin
        int x, y;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        // Sub-threshold motion stays idle.
        sample(100, 100);
        sample(105, 102);
        // 40 px jump opens a swing from (100,100).
        sample(100, 100);
        sample(130, 110);
        // Still frames end the swing, then cooldown swallows 10 moving samples.
        sample(160, 120);
        for (int i = 0; i < 3; i++) sample(162, 121);
        x = 162;
        for (int i = 0; i < 11; i++) begin
            x = (i % 2 == 0) ? 212 : 162;
            sample(x, 121);
        end
        // Held intersection yields a single hit.
        for (int i = 0; i < 5; i++) cyc(0, 0, x, 121, 1);
        for (int i = 0; i < 3; i++) sample(x, 122);
        for (int i = 0; i < 10; i++) sample(x, 122);
        sample(x + 60, 122);
        cyc(0, 0, x + 60, 122, 1);
        cyc(0, 1, x + 65, 123, 1);
        // Reset mid-swing while intersecting; next sample only seeds.
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        sample(500, 500);
        sample(600, 600);
        cyc(1, 0, 0, 0, 0);
        // Continuous 20 px/frame motion.
        sample(200, 300);
        for (int i = 1; i <= 25; i++) sample(200 + 20 * i, 300);
        cyc(1, 0, 0, 0, 0);
        // Randomized traffic.
        x = 1000; y = 500;
        for (int i = 0; i < 3000; i++) begin
            int r, step;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                x = int'($urandom_range(0, 2047));
                y = int'($urandom_range(0, 1023));
            end else if (r < 40) begin
                x += int'($urandom_range(0, 8)) - 4;
                y += int'($urandom_range(0, 8)) - 4;
            end else begin
                step = int'($urandom_range(10, 40));
                x += ($urandom_range(0, 1) == 1) ? step : -step;
                y += int'($urandom_range(0, 20)) - 10;
            end
            if (x < 0) x = 0;
            if (x > 2047) x = 2047;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            cyc(r == 99, $urandom_range(0, 1) == 1, x, y, $urandom_range(0, 4) == 0);
        end
        cyc(0, 0, x, y, 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_in);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
